// File: rtl/fifo_clk_dual_pkg.sv
// Default geometry for the single-clock elastic FIFO and its derived pointer width.
package fifo_clk_dual_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;
  localparam int CNT_W_DEF  = 4;
  localparam int PTR_W_DEF  = $clog2(DEPTH_DEF);
endpackage

// File: rtl/fifo_clk_dual_mem.sv
// FIFO storage: synchronous write port, registered read port (one edge), holds when idle.
// Array contents are not reset; only the read-data register is.
module fifo_clk_dual_mem
  import fifo_clk_dual_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PTR_W  = PTR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rd_data <= '0;
    else if (rd) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_clk_dual.sv
// Single-clock FIFO; one-edge registered read, flags decoded from the occupancy counter.
// No backpressure beyond flags: writes when full / reads when empty are dropped; FIFO_CLK_DUAL_ERR_FLAGS_EN adds overflow/underflow pulses.
module fifo_clk_dual
  import fifo_clk_dual_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] buf_in,
  output logic [DATA_W-1:0] buf_out,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic              buf_empty,
  output logic              buf_full,
  output logic [CNT_W-1:0]  fifo_counter
`ifdef FIFO_CLK_DUAL_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign buf_empty = (fifo_counter == '0);
  assign buf_full  = (fifo_counter == CNT_W'(DEPTH));
  assign wr_ok     = wr_en && !buf_full;
  assign rd_ok     = rd_en && !buf_empty;

  // Pointers wrap by natural overflow since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_counter <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   fifo_counter <= fifo_counter + CNT_W'(1);
        2'b01:   fifo_counter <= fifo_counter - CNT_W'(1);
        default: fifo_counter <= fifo_counter;
      endcase
    end
  end

`ifdef FIFO_CLK_DUAL_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && buf_full;
      underflow <= rd_en && buf_empty;
    end
  end
`endif

  fifo_clk_dual_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (buf_in),
    .rd      (rd_ok),
    .rd_addr (rd_ptr),
    .rd_data (buf_out)
  );

endmodule

// File: tb/tb_fifo_clk_dual.sv
// Directed self-checking bench for fifo_clk_dual (optionally with FIFO_CLK_DUAL_ERR_FLAGS_EN).
module tb_fifo_clk_dual;

  logic       clk;
  logic       rst_n;
  logic [7:0] buf_in;
  logic [7:0] buf_out;
  logic       wr_en;
  logic       rd_en;
  logic       buf_empty;
  logic       buf_full;
  logic [3:0] fifo_counter;
`ifdef FIFO_CLK_DUAL_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  int checks   = 0;
  int failures = 0;

  fifo_clk_dual dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .buf_in       (buf_in),
    .buf_out      (buf_out),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .buf_empty    (buf_empty),
    .buf_full     (buf_full),
    .fifo_counter (fifo_counter)
`ifdef FIFO_CLK_DUAL_ERR_FLAGS_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] v);
    buf_in = v;
    wr_en  = 1'b1;
    tick();
    wr_en  = 1'b0;
  endtask

  task automatic rd();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic both(input logic [7:0] v);
    buf_in = v;
    wr_en  = 1'b1;
    rd_en  = 1'b1;
    tick();
    wr_en  = 1'b0;
    rd_en  = 1'b0;
  endtask

  logic [7:0] exp_q[$];

  initial begin
    rst_n  = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    buf_in = 8'h00;
    repeat (3) tick();
    chk("rst_empty_low", 32'(buf_empty), 32'd1);
    rst_n = 1'b1;
    tick();
    chk("rst_empty", 32'(buf_empty), 32'd1);
    chk("rst_full", 32'(buf_full), 32'd0);
    chk("rst_cnt", 32'(fifo_counter), 32'd0);
    chk("rst_out", 32'(buf_out), 32'd0);
`ifdef FIFO_CLK_DUAL_ERR_FLAGS_EN
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
`endif

    // Basic ordering
    wr(8'd11); wr(8'd22); wr(8'd33); wr(8'd44); wr(8'd55);
    chk("cnt5", 32'(fifo_counter), 32'd5);
    chk("not_empty", 32'(buf_empty), 32'd0);
    rd();
    chk("rd11", 32'(buf_out), 32'd11);
    chk("cnt4", 32'(fifo_counter), 32'd4);
    rd();
    chk("rd22", 32'(buf_out), 32'd22);
    chk("cnt3", 32'(fifo_counter), 32'd3);
    wr(8'd66); wr(8'd77); wr(8'd88);
    chk("cnt6", 32'(fifo_counter), 32'd6);
    exp_q = '{8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88};
    foreach (exp_q[i]) begin
      rd();
      chk("drain6", 32'(buf_out), 32'(exp_q[i]));
    end
    chk("drain6_empty", 32'(buf_empty), 32'd1);
    chk("drain6_cnt", 32'(fifo_counter), 32'd0);

    // Read while empty is ignored
    rd();
    chk("unf_out", 32'(buf_out), 32'd88);
    chk("unf_cnt", 32'(fifo_counter), 32'd0);
`ifdef FIFO_CLK_DUAL_ERR_FLAGS_EN
    chk("unf_pulse", 32'(underflow), 32'd1);
    tick();
    chk("unf_clear", 32'(underflow), 32'd0);
`endif

    // Offset pointers by one so the fill wraps across entry 7 -> 0
    wr(8'h5A);
    rd();
    chk("offset_rd", 32'(buf_out), 32'h5A);

    for (int i = 0; i < 8; i++) wr(8'hA0 + 8'(i));
    chk("fill_full", 32'(buf_full), 32'd1);
    chk("fill_cnt", 32'(fifo_counter), 32'd8);
    wr(8'd99);
    chk("ovf_cnt", 32'(fifo_counter), 32'd8);
    chk("ovf_full", 32'(buf_full), 32'd1);
`ifdef FIFO_CLK_DUAL_ERR_FLAGS_EN
    chk("ovf_pulse", 32'(overflow), 32'd1);
    tick();
    chk("ovf_clear", 32'(overflow), 32'd0);
`endif
    for (int i = 0; i < 8; i++) begin
      rd();
      chk("wrap_drain", 32'(buf_out), 32'(8'hA0 + 8'(i)));
    end
    chk("wrap_empty", 32'(buf_empty), 32'd1);

    // Simultaneous read/write at count 3
    wr(8'hC1); wr(8'hC2); wr(8'hC3);
    both(8'hC4);
    chk("sim3_cnt", 32'(fifo_counter), 32'd3);
    chk("sim3_out", 32'(buf_out), 32'hC1);
    rd(); chk("sim3_d2", 32'(buf_out), 32'hC2);
    rd(); chk("sim3_d3", 32'(buf_out), 32'hC3);
    rd(); chk("sim3_d4", 32'(buf_out), 32'hC4);
    chk("sim3_empty", 32'(buf_empty), 32'd1);

    // Simultaneous at count 0: only the write is accepted
    both(8'hD1);
    chk("sim0_cnt", 32'(fifo_counter), 32'd1);
    chk("sim0_out", 32'(buf_out), 32'hC4);
    for (int i = 2; i <= 8; i++) wr(8'hD0 + 8'(i));
    chk("sim8_full", 32'(buf_full), 32'd1);

    // Simultaneous at count 8: only the read is accepted
    both(8'hE0);
    chk("sim8_cnt", 32'(fifo_counter), 32'd7);
    chk("sim8_out", 32'(buf_out), 32'hD1);
    chk("sim8_notfull", 32'(buf_full), 32'd0);
    rd(); chk("post8_d2", 32'(buf_out), 32'hD2);
    rd(); chk("post8_d3", 32'(buf_out), 32'hD3);
    rd(); chk("post8_d4", 32'(buf_out), 32'hD4);
    chk("pre_rst_cnt", 32'(fifo_counter), 32'd4);

    // Asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(fifo_counter), 32'd0);
    chk("arst_empty", 32'(buf_empty), 32'd1);
    chk("arst_full", 32'(buf_full), 32'd0);
    chk("arst_out", 32'(buf_out), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    wr(8'hF1);
    chk("post_rst_cnt", 32'(fifo_counter), 32'd1);
    rd();
    chk("post_rst_out", 32'(buf_out), 32'hF1);
    chk("post_rst_empty", 32'(buf_empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
